// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, reset PC, fetch state
// encoding and the branch target helper used by IF, EX and tests.
package cpu_pkg;

  localparam logic [31:0] CPU_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_EMPTY = 2'd0,
    FS_MEM   = 2'd1,
    FS_SKID  = 2'd2
  } fetch_state_t;

  // pc4 + (sext(imm16) << 2), wrapping modulo 2^32
  function automatic logic [31:0] branch_target(
    input logic [31:0] pc4,
    input logic [15:0] imm16
  );
    return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// One-entry skid buffer holding {inst, pc} across a decode stall.
// Ports: clk, load_i, clear_i (wins over load), data_i, data_o, valid_o.
module skid_buffer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic         vld_q;

  always_ff @(posedge clk) begin
    if (clear_i) begin
      vld_q <= 1'b0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = vld_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle imem requests, stall skid, redirect.
// Ports: clk, reset, imem_*, if_stall, br_*, if_valid/if_inst/if_pc4.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter int          IMEM_AW  = 10,
  parameter logic [31:0] NOP_INST = CPU_NOP_INST
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               if_stall,
  input  logic               br_taken,
  input  logic [31:0]        br_pc4,
  input  logic [15:0]        br_imm16,
  output logic               if_valid,
  output logic [31:0]        if_inst,
  output logic [31:0]        if_pc4
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         req_vld_q, req_vld_d;
  logic         skid_vld;
  logic         skid_load, skid_clr;
  logic [31:0]  skid_inst, skid_pc;
  logic         hold;
  fetch_state_t st;

  skid_buffer #(.W(64)) u_skid (
    .clk     (clk),
    .load_i  (skid_load),
    .clear_i (skid_clr),
    .data_i  ({imem_rdata, req_pc_q}),
    .data_o  ({skid_inst, skid_pc}),
    .valid_o (skid_vld)
  );

  always_comb begin
    if (skid_vld)       st = FS_SKID;
    else if (req_vld_q) st = FS_MEM;
    else                st = FS_EMPTY;
  end

  assign hold = if_stall & (st != FS_EMPTY);

  always_comb begin
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    req_vld_d = req_vld_q;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    priority case (1'b1)
      reset: begin
        pc_d      = RESET_PC;
        req_pc_d  = '0;
        req_vld_d = 1'b0;
        skid_clr  = 1'b1;
      end
      br_taken: begin
        pc_d      = branch_target(br_pc4, br_imm16);
        req_vld_d = 1'b0;
        skid_clr  = 1'b1;
      end
      hold: begin
        // in-flight read parks in the skid; a full skid just holds
        req_vld_d = 1'b0;
        skid_load = (st == FS_MEM);
      end
      default: begin
        // skid (if any) is consumed while the next read issues
        req_pc_d  = pc_q;
        req_vld_d = 1'b1;
        pc_d      = pc_q + 32'd4;
        skid_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      req_vld_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      req_vld_q <= req_vld_d;
    end
  end

  assign imem_en   = !reset & !br_taken & !hold;
  assign imem_addr = pc_q[IMEM_AW+1:2];

  assign if_valid = (st != FS_EMPTY) & !br_taken & !reset;
  assign if_inst  = !if_valid ? NOP_INST
                  : skid_vld ? skid_inst : imem_rdata;
  assign if_pc4   = reset ? 32'd4
                  : (skid_vld ? skid_pc : req_pc_q) + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, branch,
// branch-in-skid, reset-in-skid and PC wrap.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] M = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset, if_stall, br_taken;
  logic [31:0] br_pc4;
  logic [15:0] br_imm16;
  logic        imem_en, if_valid;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, if_inst, if_pc4;

  logic        w_en, w_valid;
  logic [9:0]  w_addr;
  logic [31:0] w_rdata, w_inst, w_pc4;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'd0;
  logic [15:0] zero16 = 16'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk        (clk),
    .reset      (reset),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_stall   (if_stall),
    .br_taken   (br_taken),
    .br_pc4     (br_pc4),
    .br_imm16   (br_imm16),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc4     (if_pc4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk        (clk),
    .reset      (reset),
    .imem_en    (w_en),
    .imem_addr  (w_addr),
    .imem_rdata (w_rdata),
    .if_stall   (zero1),
    .br_taken   (zero1),
    .br_pc4     (zero32),
    .br_imm16   (zero16),
    .if_valid   (w_valid),
    .if_inst    (w_inst),
    .if_pc4     (w_pc4)
  );

  // word k holds M + k
  always_ff @(posedge clk) begin
    if (imem_en) imem_rdata <= M + {22'd0, imem_addr};
    if (w_en)    w_rdata    <= M + {22'd0, w_addr};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // v/inst/pc4 checked together; pc4 only meaningful when valid
  task automatic look(input string tag, input logic v,
                      input logic [31:0] inst,
                      input logic [31:0] pc4,
                      input logic en);
    #1;
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".inst"}, if_inst, inst);
    if (v) chk({tag, ".pc4"}, if_pc4, pc4);
    chk({tag, ".en"}, {31'd0, imem_en}, {31'd0, en});
  endtask

  initial begin
    reset = 1'b1; if_stall = 1'b0; br_taken = 1'b0;
    br_pc4 = '0; br_imm16 = '0;
    step; step;
    look("rst", 1'b0, 32'd0, 32'd4, 1'b0);
    chk("rst.pc4", if_pc4, 32'd4);
    chk("rst.wvalid", {31'd0, w_valid}, 32'd0);

    reset = 1'b0;
    look("A", 1'b0, 32'd0, 32'd0, 1'b1);
    chk("A.addr", {22'd0, imem_addr}, 32'd0);
    chk("A.waddr", {22'd0, w_addr}, 32'h3FF);
    step;
    look("B", 1'b1, M, 32'd4, 1'b1);
    chk("B.addr", {22'd0, imem_addr}, 32'd1);
    chk("B.wvalid", {31'd0, w_valid}, 32'd1);
    chk("B.winst", w_inst, M + 32'h3FF);
    chk("B.wpc4", w_pc4, 32'd0);
    chk("B.waddr", {22'd0, w_addr}, 32'd0);
    step;
    look("C", 1'b1, M + 1, 32'd8, 1'b1);
    chk("C.winst", w_inst, M);
    chk("C.wpc4", w_pc4, 32'd4);
    step;

    if_stall = 1'b1;
    look("D", 1'b1, M + 2, 32'd12, 1'b0);
    step;
    look("E", 1'b1, M + 2, 32'd12, 1'b0);
    step;
    look("F", 1'b1, M + 2, 32'd12, 1'b0);
    step;
    if_stall = 1'b0;
    look("G", 1'b1, M + 2, 32'd12, 1'b1);
    chk("G.addr", {22'd0, imem_addr}, 32'd3);
    step;
    look("H", 1'b1, M + 3, 32'd16, 1'b1);
    step;

    br_taken = 1'b1; br_pc4 = 32'h20; br_imm16 = 16'hFFFC;
    look("I", 1'b0, 32'd0, 32'd0, 1'b0);
    step;
    br_taken = 1'b0;
    look("J", 1'b0, 32'd0, 32'd0, 1'b1);
    chk("J.addr", {22'd0, imem_addr}, 32'd4);
    step;
    look("K", 1'b1, M + 4, 32'h14, 1'b1);

    if_stall = 1'b1;
    look("K2", 1'b1, M + 4, 32'h14, 1'b0);
    step;
    br_taken = 1'b1; br_pc4 = 32'd8; br_imm16 = 16'd3;
    look("L", 1'b0, 32'd0, 32'd0, 1'b0);
    step;
    br_taken = 1'b0; if_stall = 1'b0;
    look("M", 1'b0, 32'd0, 32'd0, 1'b1);
    chk("M.addr", {22'd0, imem_addr}, 32'd5);
    step;
    look("N", 1'b1, M + 5, 32'h18, 1'b1);

    if_stall = 1'b1;
    step;
    look("O0", 1'b1, M + 5, 32'h18, 1'b0);
    reset = 1'b1;
    look("O", 1'b0, 32'd0, 32'd0, 1'b0);
    chk("O.pc4", if_pc4, 32'd4);
    step;
    reset = 1'b0; if_stall = 1'b0;
    look("P", 1'b0, 32'd0, 32'd0, 1'b1);
    chk("P.addr", {22'd0, imem_addr}, 32'd0);
    step;
    look("Q", 1'b1, M, 32'd4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
